// File: rtl/mips_dbg_loader.sv
// Host debug/loader port: program-memory writes, register readback, core hold/release; MIPS_DBG_AUTOINC_EN selects pointer-addressed writes.
// Latency: WRMEM rsp at T+2, RDREG T+3 (range error T+1), RUN T+2, STOP T+1; one command outstanding.
// Backpressure: response held until rsp_ready; cmd_ready low from accept until the cycle after the response handshake.
module mips_dbg_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [4:0]        reg_raddr,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              cpu_hold,
  output logic              cpu_pc_clr,
  input  logic              cpu_halted
);

  localparam logic [1:0] OP_WRMEM = 2'b00;
  localparam logic [1:0] OP_RDREG = 2'b01;
  localparam logic [1:0] OP_RUN   = 2'b10;
  localparam logic [1:0] OP_STOP  = 2'b11;

  typedef enum logic [2:0] {IDLE, MEMWR, REGRD0, REGRD1, RESP, RUNNING} state_t;

  state_t            state;
  logic              released;  // core let go by RUN and not yet stopped or halted
  logic              run_pend;  // RUN response still owed on the cycle after release
  logic              accept;
  logic              reg_ok;
  logic [ADDR_W-1:0] wr_addr;

`ifdef MIPS_DBG_AUTOINC_EN
  logic [ADDR_W-1:0] wr_ptr;
  assign wr_addr = wr_ptr;
`else
  assign wr_addr = cmd_addr;
`endif

  assign cmd_ready = (state == IDLE || (state == RUNNING && !run_pend)) && !rsp_valid;
  assign accept    = cmd_valid && cmd_ready;
  assign reg_ok    = (cmd_addr >> 5) == '0;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      released   <= 1'b0;
      run_pend   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      reg_raddr  <= '0;
      cpu_hold   <= 1'b1;
      cpu_pc_clr <= 1'b0;
`ifdef MIPS_DBG_AUTOINC_EN
      wr_ptr     <= '0;
`endif
    end else begin
      mem_we     <= 1'b0;
      cpu_pc_clr <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (cmd_op)
              OP_WRMEM: begin
                mem_we    <= 1'b1;
                mem_addr  <= wr_addr;
                mem_wdata <= cmd_data;
                rsp_data  <= cmd_data;
                state     <= MEMWR;
`ifdef MIPS_DBG_AUTOINC_EN
                wr_ptr    <= wr_ptr + 1'b1;
`endif
              end
              OP_RDREG: begin
                if (reg_ok) begin
                  reg_raddr <= cmd_addr[4:0];
                  state     <= REGRD0;
                end else begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_data  <= '0;
                  state     <= RESP;
                end
              end
              OP_RUN: begin
                cpu_pc_clr <= 1'b1;
                cpu_hold   <= 1'b0;
                released   <= 1'b1;
                run_pend   <= 1'b1;
                state      <= RUNNING;
              end
              default: begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b0;
                rsp_data  <= '0;
                state     <= RESP;
`ifdef MIPS_DBG_AUTOINC_EN
                wr_ptr    <= '0;
`endif
              end
            endcase
          end
        end
        MEMWR: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          state     <= RESP;
        end
        REGRD0: state <= REGRD1;
        REGRD1: begin
          rsp_data  <= reg_rdata;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          state     <= RESP;
        end
        RUNNING: begin
          if (run_pend) begin
            run_pend  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            state     <= RESP;
          end else if (accept) begin
            // STOP wins over a simultaneous halt so the host still gets its answer
            rsp_valid <= 1'b1;
            rsp_data  <= '0;
            state     <= RESP;
            if (cmd_op == OP_STOP) begin
              rsp_err  <= 1'b0;
              cpu_hold <= 1'b1;
              released <= 1'b0;
`ifdef MIPS_DBG_AUTOINC_EN
              wr_ptr   <= '0;
`endif
            end else begin
              rsp_err <= 1'b1;
            end
          end else if (cpu_halted) begin
            cpu_hold <= 1'b1;
            released <= 1'b0;
            state    <= IDLE;
          end
        end
        RESP: begin
          if (released && cpu_halted) begin
            cpu_hold <= 1'b1;
            released <= 1'b0;
          end
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            state     <= (released && !cpu_halted) ? RUNNING : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_dbg_loader.sv
// Directed bench for mips_dbg_loader with a registered register-file model behind reg_raddr/reg_rdata.
module tb_mips_dbg_loader;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam logic [1:0] WRMEM = 2'b00, RDREG = 2'b01, RUN = 2'b10, STOP = 2'b11;

  logic          clk1 = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_data = '0;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [DW-1:0] rsp_data;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [4:0]    reg_raddr;
  logic [DW-1:0] reg_rdata = '0;
  logic          cpu_hold, cpu_pc_clr, cpu_halted = 1'b0;

  int tests = 0, fails = 0, we_cnt = 0, cyc = 0;
  logic [DW-1:0] rf [0:31];
  logic [DW-1:0] prog [0:8];
  logic [DW-1:0] rexp [1:5];

  mips_dbg_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk1(clk1), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
    .cpu_hold(cpu_hold), .cpu_pc_clr(cpu_pc_clr), .cpu_halted(cpu_halted));

  always #5 clk1 = ~clk1;
  always @(posedge clk1) begin
    cyc <= cyc + 1;
    reg_rdata <= rf[reg_raddr];
    if (cyc > 20000) begin
      $display("FAIL watchdog: cycle %0d reached, limit 20000", cyc);
      $fatal(1, "watchdog");
    end
  end
  always @(negedge clk1) if (mem_we === 1'b1) we_cnt++;

  // Called at a negedge; returns just after the accepting edge T.
  task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_op = op; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
    @(posedge clk1); #1 cmd_valid = 1'b0;
  endtask

  // Called at a negedge with rsp_valid high; returns at the negedge after the handshake.
  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge clk1); #1 rsp_ready = 1'b0;
    @(negedge clk1);
  endtask

  task automatic test_reset();
    cmd_valid = 1'b1; cmd_op = WRMEM; cmd_addr = 10'd7; cmd_data = 32'h1234;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk1);
      tests++;
      if ({cpu_hold, cmd_ready, rsp_valid, mem_we, cpu_pc_clr} !== 5'b11000) begin
        fails++; $display("FAIL reset[%0d]: hold/rdy/rv/we/clr=%b want 11000", i,
                          {cpu_hold, cmd_ready, rsp_valid, mem_we, cpu_pc_clr});
      end
    end
    cmd_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk1);
    tests++;
    if (we_cnt !== 0) begin fails++; $display("FAIL reset_we: %0d pulses want 0", we_cnt); end
  endtask

  task automatic test_load();
    for (int i = 0; i < 9; i++) begin
      issue(WRMEM, AW'(i), prog[i]);
      @(negedge clk1);
      tests++;
      if ({mem_we, mem_addr, mem_wdata, rsp_valid, cmd_ready} !== {1'b1, AW'(i), prog[i], 2'b00}) begin
        fails++; $display("FAIL load_we[%0d]: we=%b addr=%0d dat=%h rv=%b rdy=%b want 1 %0d %h 0 0",
                          i, mem_we, mem_addr, mem_wdata, rsp_valid, cmd_ready, i, prog[i]);
      end
      @(negedge clk1);
      tests++;
      if ({mem_we, rsp_valid, rsp_err, rsp_data} !== {3'b010, prog[i]}) begin
        fails++; $display("FAIL load_rsp[%0d]: we=%b rv=%b err=%b dat=%h want 0 1 0 %h",
                          i, mem_we, rsp_valid, rsp_err, rsp_data, prog[i]);
      end
      take_rsp();
    end
    tests++;
    if (we_cnt !== 9) begin fails++; $display("FAIL load_cnt: %0d pulses want 9", we_cnt); end
  endtask

  task automatic test_run_halt();
    issue(RUN, '0, '0);
    @(negedge clk1);
    tests++;
    if ({cpu_pc_clr, cpu_hold, rsp_valid, cmd_ready} !== 4'b1000) begin
      fails++; $display("FAIL run_t1: clr/hold/rv/rdy=%b want 1000", {cpu_pc_clr, cpu_hold, rsp_valid, cmd_ready});
    end
    @(negedge clk1);
    tests++;
    if ({cpu_pc_clr, cpu_hold, rsp_valid, rsp_err, rsp_data} !== {4'b0010, 32'h0}) begin
      fails++; $display("FAIL run_t2: clr/hold/rv/err=%b dat=%h want 0010 0",
                        {cpu_pc_clr, cpu_hold, rsp_valid, rsp_err}, rsp_data);
    end
    take_rsp();
    tests++;
    if ({cmd_ready, cpu_hold} !== 2'b10) begin
      fails++; $display("FAIL running: rdy/hold=%b want 10", {cmd_ready, cpu_hold});
    end
    issue(WRMEM, 10'd5, 32'hdeadbeef);
    @(negedge clk1);
    tests++;
    if ({rsp_valid, rsp_err, rsp_data, mem_we} !== {2'b11, 32'h0, 1'b0}) begin
      fails++; $display("FAIL wr_running: rv/err=%b dat=%h we=%b want 11 0 0", {rsp_valid, rsp_err}, rsp_data, mem_we);
    end
    take_rsp();
    tests++;
    if ({we_cnt, cpu_hold} !== {32'd9, 1'b0}) begin
      fails++; $display("FAIL wr_running_fx: we_cnt=%0d hold=%b want 9 0", we_cnt, cpu_hold);
    end
    cpu_halted = 1'b1;
    @(negedge clk1);
    tests++;
    if ({cpu_hold, rsp_valid, cmd_ready} !== 3'b101) begin
      fails++; $display("FAIL halt: hold/rv/rdy=%b want 101", {cpu_hold, rsp_valid, cmd_ready});
    end
    cpu_halted = 1'b0;
  endtask

  task automatic test_rdreg();
    for (int r = 1; r <= 5; r++) begin
      issue(RDREG, AW'(r), '0);
      @(negedge clk1);
      tests++;
      if ({reg_raddr, rsp_valid} !== {5'(r), 1'b0}) begin
        fails++; $display("FAIL rd_t1[%0d]: raddr=%0d rv=%b want %0d 0", r, reg_raddr, rsp_valid, r);
      end
      @(negedge clk1);
      tests++;
      if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rd_t2[%0d]: rv=%b want 0", r, rsp_valid); end
      @(negedge clk1);
      tests++;
      if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, rexp[r]}) begin
        fails++; $display("FAIL rd_t3[%0d]: rv/err=%b dat=%0d want 10 %0d", r, {rsp_valid, rsp_err}, rsp_data, rexp[r]);
      end
      take_rsp();
    end
  endtask

  task automatic test_range();
    issue(RDREG, 10'd32, '0);
    @(negedge clk1);
    tests++;
    if ({rsp_valid, rsp_err, rsp_data, reg_raddr} !== {2'b11, 32'h0, 5'd5}) begin
      fails++; $display("FAIL range: rv/err=%b dat=%h raddr=%0d want 11 0 5", {rsp_valid, rsp_err}, rsp_data, reg_raddr);
    end
    take_rsp();
  endtask

  task automatic test_backpressure();
    issue(RDREG, 10'd3, '0);
    repeat (3) @(negedge clk1);
    for (int i = 0; i < 5; i++) begin
      tests++;
      if ({rsp_valid, rsp_data, cmd_ready} !== {1'b1, 32'd25, 1'b0}) begin
        fails++; $display("FAIL bp[%0d]: rv=%b dat=%0d rdy=%b want 1 25 0", i, rsp_valid, rsp_data, cmd_ready);
      end
      @(negedge clk1);
    end
    take_rsp();
    tests++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      fails++; $display("FAIL bp_done: rv/rdy=%b want 01", {rsp_valid, cmd_ready});
    end
  endtask

  task automatic test_stop();
    issue(STOP, '0, '0);
    @(negedge clk1);
    tests++;
    if ({rsp_valid, rsp_err, cpu_hold} !== 3'b101) begin
      fails++; $display("FAIL stop_idle: rv/err/hold=%b want 101", {rsp_valid, rsp_err, cpu_hold});
    end
    take_rsp();
    issue(RUN, '0, '0);
    repeat (2) @(negedge clk1);
    take_rsp();
    cpu_halted = 1'b1;
    issue(STOP, '0, '0);
    @(negedge clk1);
    tests++;
    if ({rsp_valid, rsp_err, cpu_hold} !== 3'b101) begin
      fails++; $display("FAIL stop_race: rv/err/hold=%b want 101", {rsp_valid, rsp_err, cpu_hold});
    end
    take_rsp();
    cpu_halted = 1'b0;
    tests++;
    if ({rsp_valid, cmd_ready, cpu_hold} !== 3'b011) begin
      fails++; $display("FAIL stop_idle_ret: rv/rdy/hold=%b want 011", {rsp_valid, cmd_ready, cpu_hold});
    end
  endtask

`ifdef MIPS_DBG_AUTOINC_EN
  task automatic test_autoinc();
    issue(STOP, '0, '0);
    @(negedge clk1);
    take_rsp();
    for (int i = 0; i < 3; i++) begin
      issue(WRMEM, 10'h3FF, 32'hA0 + 32'(i));
      @(negedge clk1);
      tests++;
      if ({mem_we, mem_addr} !== {1'b1, AW'(i)}) begin
        fails++; $display("FAIL autoinc[%0d]: we=%b addr=%0d want 1 %0d", i, mem_we, mem_addr, i);
      end
      @(negedge clk1);
      take_rsp();
    end
    for (int i = 3; i < 1025; i++) begin
      issue(WRMEM, 10'h3FF, 32'(i));
      @(negedge clk1);
      if (i == 1024) begin
        tests++;
        if ({mem_we, mem_addr} !== {1'b1, 10'd0}) begin
          fails++; $display("FAIL autoinc_wrap: we=%b addr=%0d want 1 0", mem_we, mem_addr);
        end
      end
      @(negedge clk1);
      take_rsp();
    end
  endtask
`endif

  task automatic test_reset_mid();
    issue(WRMEM, 10'd20, 32'h55);
    @(negedge clk1);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({mem_we, rsp_valid, cpu_hold} !== 3'b001) begin
      fails++; $display("FAIL rst_mid_wr: we/rv/hold=%b want 001", {mem_we, rsp_valid, cpu_hold});
    end
    @(negedge clk1); rst_n = 1'b1;
    @(negedge clk1);
    issue(RUN, '0, '0);
    @(negedge clk1);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({cpu_hold, cpu_pc_clr, rsp_valid} !== 3'b100) begin
      fails++; $display("FAIL rst_mid_run: hold/clr/rv=%b want 100", {cpu_hold, cpu_pc_clr, rsp_valid});
    end
    @(negedge clk1); rst_n = 1'b1;
    @(negedge clk1);
    tests++;
    if ({cmd_ready, rsp_valid, cpu_hold} !== 3'b101) begin
      fails++; $display("FAIL rst_mid_after: rdy/rv/hold=%b want 101", {cmd_ready, rsp_valid, cpu_hold});
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rf[1] = 32'd10; rf[2] = 32'd20; rf[3] = 32'd25; rf[4] = 32'd30; rf[5] = 32'd55;
    rexp[1] = 32'd10; rexp[2] = 32'd20; rexp[3] = 32'd25; rexp[4] = 32'd30; rexp[5] = 32'd55;
    prog[0] = 32'h2801000a; prog[1] = 32'h28020014; prog[2] = 32'h28030019;
    prog[3] = 32'h0ce77800; prog[4] = 32'h0ce77800; prog[5] = 32'h00222000;
    prog[6] = 32'h0ce77800; prog[7] = 32'h00832800; prog[8] = 32'hfc000000;
    test_reset();
    test_load();
    test_run_halt();
    test_rdreg();
    test_range();
    test_backpressure();
    test_stop();
`ifdef MIPS_DBG_AUTOINC_EN
    test_autoinc();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
